// File: rtl/serializer_framed.sv
// Framed serializer: turns a parallel word of 2..PRL_DATA_WIDTH valid bits into
// a gated serial frame (preamble, data MSB-first, even parity) followed by an idle gap.
module serializer_framed #(
  parameter int                        PRL_DATA_WIDTH = 10,
  parameter int                        PREAMBLE_WIDTH = 4,
  parameter logic [PREAMBLE_WIDTH-1:0] PREAMBLE       = 4'b1010,
  parameter int                        IDLE_GAP       = 1,
  parameter int                        LEN_WIDTH      = $clog2(PRL_DATA_WIDTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [PRL_DATA_WIDTH-1:0] prl_data_i,
  input  logic [LEN_WIDTH-1:0]      prl_len_i,
  input  logic                      prl_valid_i,
  output logic                      prl_ready_o,
  output logic                      prl_drop_o,
  output logic                      ser_data_o,
  output logic                      ser_data_en_o,
  output logic                      busy_o
);

  localparam int MAX_A   = (PREAMBLE_WIDTH > PRL_DATA_WIDTH) ? PREAMBLE_WIDTH : PRL_DATA_WIDTH;
  localparam int MAX_CNT = (MAX_A > IDLE_GAP) ? MAX_A : IDLE_GAP;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAR,
    S_GAP
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PRL_DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic                      ser_q, ser_d;
  logic                      en_q, en_d;
  logic                      drop_q, drop_d;
  logic                      ready_q, ready_d;
  logic                      len_legal;

  function automatic logic data_bit(input logic [PRL_DATA_WIDTH-1:0] d,
                                    input logic [CNT_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < PRL_DATA_WIDTH; i++) begin
      if (CNT_W'(i) == idx) b = d[i];
    end
    return b;
  endfunction

  function automatic logic pre_bit(input logic [CNT_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < PREAMBLE_WIDTH; i++) begin
      if (CNT_W'(i) == idx) b = PREAMBLE[i];
    end
    return b;
  endfunction

  // Even parity over the low len bits only; upper bits are masked out.
  function automatic logic field_parity(input logic [PRL_DATA_WIDTH-1:0] d,
                                        input logic [LEN_WIDTH-1:0] len);
    logic p;
    p = 1'b0;
    for (int i = 0; i < PRL_DATA_WIDTH; i++) begin
      if (i < int'(len)) p = p ^ d[i];
    end
    return p;
  endfunction

  assign len_legal = (prl_len_i >= LEN_WIDTH'(2)) &&
                     (prl_len_i <= LEN_WIDTH'(PRL_DATA_WIDTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    len_d   = len_q;
    ser_d   = 1'b0;
    en_d    = 1'b0;
    drop_d  = 1'b0;
    ready_d = ready_q;
    case (state_q)
      S_IDLE: begin
        if (prl_valid_i && ready_q) begin
          if (len_legal) begin
            data_d  = prl_data_i;
            len_d   = prl_len_i;
            state_d = S_PRE;
            cnt_d   = CNT_W'(PREAMBLE_WIDTH - 1);
            ser_d   = PREAMBLE[PREAMBLE_WIDTH-1];
            en_d    = 1'b1;
            ready_d = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        en_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = CNT_W'(len_q - 1'b1);
          ser_d   = data_bit(data_q, CNT_W'(len_q - 1'b1));
        end else begin
          cnt_d = cnt_q - 1'b1;
          ser_d = pre_bit(cnt_q - 1'b1);
        end
      end
      S_DATA: begin
        en_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_PAR;
          ser_d   = field_parity(data_q, len_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
          ser_d = data_bit(data_q, cnt_q - 1'b1);
        end
      end
      S_PAR: begin
        // The cycle after parity is the first gap cycle; ready returns on the last one.
        if (IDLE_GAP > 1) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(IDLE_GAP - 2);
        end else begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      en_q    <= 1'b0;
      drop_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      len_q   <= len_d;
      ser_q   <= ser_d;
      en_q    <= en_d;
      drop_q  <= drop_d;
      ready_q <= ready_d;
    end
  end

  assign prl_ready_o   = ready_q & rst_ni;
  assign busy_o        = ~ready_q;
  assign prl_drop_o    = drop_q;
  assign ser_data_o    = ser_q;
  assign ser_data_en_o = en_q;

endmodule

// File: doc/serializer_framed.md
Name: serializer_framed

Overview:
- Upstream stage of the framed serial deserializer.
- Accepts a parallel word plus a valid-bit count over a valid/ready handshake.
- Emits one serial frame per word: preamble, data bits, then one even-parity bit, with a gated enable.
- Enable is held low for at least IDLE_GAP cycles between frames, so the downstream stage sees a falling edge on the enable as end-of-frame.

Parameters:
PRL_DATA_WIDTH, 10, maximum data bits per frame; also the width of the parallel data input
PREAMBLE_WIDTH, 4, number of preamble bits
PREAMBLE, 4'b1010, preamble pattern, sent MSB first
IDLE_GAP, 1, minimum number of enable-low cycles between frames; must be >= 1
LEN_WIDTH, $clog2(PRL_DATA_WIDTH+1), width of the length input

Ports:
clk_i  input  1  clock; the only clock
rst_ni  input  1  reset; synchronous, active-low
prl_data_i  input  PRL_DATA_WIDTH  word to send; only bits [len-1:0] are used
prl_len_i  input  LEN_WIDTH  number of valid data bits; legal range 2..PRL_DATA_WIDTH
prl_valid_i  input  1  request valid
prl_ready_o  output  1  block can accept a request
prl_drop_o  output  1  one-cycle pulse: a request with illegal length was accepted and discarded
ser_data_o  output  1  serial data bit
ser_data_en_o  output  1  serial bit qualifier; high for each frame bit
busy_o  output  1  high from the handshake until the end of the IDLE_GAP window

Behaviour:
- Reset (rst_ni low at a clock edge):
  - State goes to IDLE.
  - ser_data_o = 0, ser_data_en_o = 0, prl_drop_o = 0, busy_o = 0.
  - prl_ready_o is forced to 0 combinationally while rst_ni = 0; no handshake is taken during reset.
- Handshake: a request is accepted on a rising edge where prl_valid_i & prl_ready_o. prl_data_i and prl_len_i are captured at that edge. Inputs are ignored in all other cycles.
- FSM states: IDLE -> PREAMBLE -> DATA -> PARITY -> GAP -> IDLE.
  - IDLE: prl_ready_o = 1.
  - Legal length k: accepting moves to PREAMBLE.
  - Illegal length (k < 2 or k > PRL_DATA_WIDTH): stay in IDLE; prl_drop_o = 1 in the next cycle; no enable activity; prl_ready_o stays 1.
- Timing, with the handshake at cycle 0 and k = length (all serial outputs registered):
  - Cycles 1..PREAMBLE_WIDTH: en = 1; data = PREAMBLE[PREAMBLE_WIDTH-1] down to PREAMBLE[0].
  - Next k cycles: en = 1; data = prl_data[k-1] down to prl_data[0] (MSB of the valid field first).
  - Next cycle: en = 1; data = ^prl_data[k-1:0] (XOR of the valid bits only).
  - After that: en = 0, data = 0.
  - Frame length is PREAMBLE_WIDTH + k + 1 enable-high cycles.
- prl_ready_o:
  - Low from cycle 1 through cycle PREAMBLE_WIDTH + k + IDLE_GAP.
  - High again at cycle PREAMBLE_WIDTH + k + 1 + IDLE_GAP. This is the last enable-low cycle of the gap, so back-to-back frames are separated by exactly IDLE_GAP enable-low cycles.
- busy_o = ~prl_ready_o outside reset. busy_o is low in IDLE.
- Counter:
  - One bit counter, wide enough for max(PREAMBLE_WIDTH, PRL_DATA_WIDTH, IDLE_GAP).
  - Reloaded on each state entry; it never wraps.
- Upper data bits: bits [PRL_DATA_WIDTH-1:k] are never transmitted and never affect parity.
- Reset mid-frame:
  - Frame is aborted; en = 0 and data = 0 from the reset edge onward.
  - No parity bit and no GAP are emitted.
  - prl_ready_o = 1 in the first cycle with rst_ni = 1.
- prl_valid_i low in IDLE: outputs remain idle indefinitely. prl_valid_i may drop while prl_ready_o = 0 without effect.

Test Plan:
All scenarios use default parameters unless stated.
1. len=4, data=10'h00B -> en high for 9 cycles, serial bits 1,0,1,0,1,0,1,1,1; ready high again at cycle 10.
2. len=10, data=10'h3FF -> en high for 15 cycles: 1010, then ten 1s, then parity 0.
3. len=2, data=10'h3FE -> bits 1,0,1,0,1,0,1 (only bits [1:0]=10 used; parity 1); upper ones never appear.
4. len=1, then len=11, each with valid -> prl_drop_o pulses once per request the cycle after acceptance; en stays 0; ready stays 1.
5. valid held high, two requests len=3 -> en has exactly one low cycle between frames. Repeat with IDLE_GAP=3 -> exactly three low cycles; ready rises on the last of them.
6. rst_ni pulled low during the second data bit of a len=6 frame -> en = 0 from the reset edge; no parity bit emitted; ready = 1 on the first cycle after rst_ni returns high; a new len=2 frame then transmits correctly.
